// File: rtl/calculate_layer3_mac_acc_if.sv
// Product-in / result-out bundle between the layer-3 multiplier, this accumulator
// and the activation stage. Handshake: a beat moves when valid and ready are both high under ce.
interface calculate_layer3_mac_acc_if #(
    parameter int PROD_WIDTH = 71,
    parameter int BIAS_WIDTH = 32,
    parameter int OUT_WIDTH  = 32
);
    logic                  prod_valid;
    logic                  in_ready;
    logic [PROD_WIDTH-1:0] prod;
    logic [BIAS_WIDTH-1:0] bias;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  dout;
    logic                  sat;

    modport master (
        output prod_valid, prod, bias, out_ready,
        input  in_ready, out_valid, dout, sat
    );

    modport slave (
        input  prod_valid, prod, bias, out_ready,
        output in_ready, out_valid, dout, sat
    );
endinterface

// File: rtl/calculate_layer3_mac_acc.sv
// Sums TAPS signed products plus a pre-shifted bias, rescales by SHIFT and saturates
// to OUT_WIDTH; holds the result on a valid/ready output. ce freezes everything.
module calculate_layer3_mac_acc #(
    parameter int PROD_WIDTH = 71,
    parameter int BIAS_WIDTH = 32,
    parameter int ACC_WIDTH  = 80,
    parameter int OUT_WIDTH  = 32,
    parameter int SHIFT      = 16,
    parameter int TAPS       = 150
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    calculate_layer3_mac_acc_if.slave bus,
    output logic dbg_state_o
);
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]        dout_q, dout_d;
    logic                        sat_q, sat_d;

    logic                        in_ready;
    logic                        accept, transfer, first_tap, last_tap;
    logic signed [ACC_WIDTH-1:0] bias_ext, prod_ext, acc_base, acc_next, q;
    logic [OUT_WIDTH-1:0]        dout_next;
    logic                        sat_next;

    assign accept    = ce & bus.prod_valid & in_ready;
    assign transfer  = ce & out_valid_q & bus.out_ready;
    assign first_tap = (cnt_q == '0);
    assign last_tap  = (cnt_q == CNT_LAST);

    // Bias is scaled up so it sits at the same binary point as the products.
    assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bus.bias[BIAS_WIDTH-1]}}, bus.bias};
    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.prod[PROD_WIDTH-1]}}, bus.prod};
    assign acc_base = first_tap ? (bias_ext <<< SHIFT) : acc_q;
    assign acc_next = acc_base + prod_ext;
    assign q        = acc_next >>> SHIFT;

    always_comb begin
        dout_next = q[OUT_WIDTH-1:0];
        sat_next  = 1'b0;
        if (q > OUT_MAX) begin
            dout_next = OUT_MAX[OUT_WIDTH-1:0];
            sat_next  = 1'b1;
        end else if (q < OUT_MIN) begin
            dout_next = OUT_MIN[OUT_WIDTH-1:0];
            sat_next  = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && last_tap) state_d = ST_HOLD;
            ST_HOLD:  if (transfer)           state_d = ST_ACCUM;
            default:                          state_d = ST_ACCUM;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready    = (state_q == ST_ACCUM);
        dbg_state_o = state_q;
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        sat_d       = sat_q;
        if (accept) begin
            acc_d = acc_next;
            if (last_tap) begin
                cnt_d       = '0;
                dout_d      = dout_next;
                sat_d       = sat_next;
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (transfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
        end else if (ce) begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.sat       = sat_q;
endmodule
